// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem two-port arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// RD_LAT-stage shift register carrying {valid, id} alongside the dmem read latency.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [RD_LAT-1:0] stages;

    always_ff @(posedge clock) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port dmem between
// the load/store path and an auxiliary master; steers read data back by tag.
module dmem_arbiter #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = dmem_arb_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    import dmem_arb_pkg::*;

    arb_state_e        state, state_nx;
    logic              last;
    logic              win_valid;
    logic              win_id;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] data_hold;
    rd_tag_t           tag_in, tag_out;

    // A lock owner whose req has dropped falls through to normal arbitration.
    always_comb begin
        win_valid = 1'b0;
        win_id    = REQ_CPU;
        state_nx  = IDLE;
        gnt       = '0;

        if (state == LOCK0 && req[0]) begin
            win_valid = 1'b1;
            win_id    = REQ_CPU;
        end else if (state == LOCK1 && req[1]) begin
            win_valid = 1'b1;
            win_id    = REQ_AUX;
        end else if (req == 2'b11) begin
            win_valid = 1'b1;
            win_id    = ~last;
        end else if (req[0]) begin
            win_valid = 1'b1;
            win_id    = REQ_CPU;
        end else if (req[1]) begin
            win_valid = 1'b1;
            win_id    = REQ_AUX;
        end

        if (win_valid) begin
            gnt = (win_id == REQ_AUX) ? 2'b10 : 2'b01;
            if (lock[win_id]) begin
                state_nx = (win_id == REQ_AUX) ? LOCK1 : LOCK0;
            end
        end
    end

    always_comb begin
        mem_address = addr_hold;
        mem_data    = data_hold;
        mem_wren    = 1'b0;
        if (win_valid) begin
            mem_address = (win_id == REQ_AUX) ? addr1 : addr0;
            mem_data    = (win_id == REQ_AUX) ? wdata1 : wdata0;
            mem_wren    = we[win_id];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            state <= state_nx;
            if (win_valid) begin
                last      <= win_id;
                addr_hold <= mem_address;
                data_hold <= mem_data;
            end
        end
    end

    assign tag_in.valid = win_valid & ~we[win_id];
    assign tag_in.id    = win_id;

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_tag_pipe (
        .clock  (clock),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    // mem_q lines up with the tag leaving the pipe; both are captured together.
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag_out.valid) begin
                rvalid[tag_out.id] <= 1'b1;
                rdata              <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a latency-matched syncram model.
module tb_dmem_arbiter;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    req, lock, we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mem_data, mem_q;
    logic [AW-1:0] mem_address;
    logic          mem_wren;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .RD_LAT(RD_LAT),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    // Syncram model: mem_q is valid RD_LAT cycles after the address cycle.
    logic          preload;
    logic [DW-1:0] mem   [4096];
    logic [DW-1:0] qpipe [RD_LAT];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[12'h010] <= 32'hDEADBEEF;
            mem[12'h030] <= 32'hA0A00030;
            mem[12'h031] <= 32'hA0A00031;
            mem[12'h040] <= 32'hB0B00040;
            mem[12'h041] <= 32'hB0B00041;
            mem[12'h050] <= 32'hC0C00050;
        end else if (mem_wren) begin
            mem[mem_address] <= mem_data;
        end
        qpipe[0] <= mem[mem_address];
        for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
    end

    assign mem_q = qpipe[RD_LAT-1];

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t e;
    always @(negedge clock) begin
        if (mon_en && rvalid !== 2'b00) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got %b, expected 00 (cycle %0d)", rvalid, cyc);
            end else begin
                e = sb.pop_front();
                check("rvalid", {30'd0, rvalid}, (e.id ? 32'd2 : 32'd1));
                check("rdata", rdata, e.data);
                check("rvalid_cycle", cyc, e.due);
            end
        end
    end

    task automatic beat(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] eg, input logic [DW-1:0] ed);
        logic wid;
        @(negedge clock);
        req = r; lock = l; we = w;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #1;
        check("gnt", {30'd0, gnt}, {30'd0, eg});
        if (eg != 2'b00) begin
            wid = eg[1];
            check("mem_address", mem_address, wid ? a1 : a0);
            check("mem_wren", mem_wren, w[wid]);
            if (w[wid]) check("mem_data", mem_data, wid ? d1 : d0);
            else sb.push_back('{id: wid, data: ed, due: cyc + int'(RD_LAT) + 1});
        end else begin
            check("mem_wren_nogrant", mem_wren, 1'b0);
        end
    endtask

    task automatic idle(input int n, input logic [AW-1:0] hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            req = '0; lock = '0; we = '0;
            #1;
            check("idle_gnt", {30'd0, gnt}, 32'd0);
            check("idle_wren", mem_wren, 1'b0);
            check("idle_addr_hold", mem_address, hold);
        end
    endtask

    task automatic drain();
        @(negedge clock);
        req = '0; lock = '0; we = '0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clock);
            #2;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req = '0; lock = '0; we = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_data", mem_data, 32'd0);
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        req = '0; lock = '0; we = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clock);
        preload = 1'b0;
        reset   = 1'b0;
        #1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_data", mem_data, 32'd0);
        mon_en = 1'b1;

        // single read from requester 0
        beat(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 0, 0, 2'b01, 32'hDEADBEEF);
        drain();

        // tie from reset alternates starting with requester 0
        do_reset();
        beat(2'b11, 2'b00, 2'b00, 12'h030, 12'h040, 0, 0, 2'b01, 32'hA0A00030);
        beat(2'b11, 2'b00, 2'b00, 12'h031, 12'h040, 0, 0, 2'b10, 32'hB0B00040);
        beat(2'b11, 2'b00, 2'b00, 12'h031, 12'h041, 0, 0, 2'b01, 32'hA0A00031);
        beat(2'b11, 2'b00, 2'b00, 12'h032, 12'h041, 0, 0, 2'b10, 32'hB0B00041);
        drain();

        // requester 0 alone leaves last=0, so requester 1 wins the next tie and locks
        beat(2'b01, 2'b00, 2'b00, 12'h050, 12'h000, 0, 0, 2'b01, 32'hC0C00050);
        beat(2'b11, 2'b10, 2'b10, 12'h050, 12'h100, 0, 1, 2'b10, 0);
        beat(2'b11, 2'b10, 2'b10, 12'h050, 12'h101, 0, 2, 2'b10, 0);
        beat(2'b11, 2'b00, 2'b10, 12'h050, 12'h102, 0, 3, 2'b10, 0);
        beat(2'b01, 2'b00, 2'b00, 12'h050, 12'h102, 0, 0, 2'b01, 32'hC0C00050);
        beat(2'b10, 2'b00, 2'b00, 12'h000, 12'h100, 0, 0, 2'b10, 32'd1);
        beat(2'b10, 2'b00, 2'b00, 12'h000, 12'h101, 0, 0, 2'b10, 32'd2);
        beat(2'b10, 2'b00, 2'b00, 12'h000, 12'h102, 0, 0, 2'b10, 32'd3);
        drain();

        // write then read-after-write on consecutive cycles
        beat(2'b01, 2'b00, 2'b01, 12'h020, 12'h000, 32'h55, 0, 2'b01, 0);
        beat(2'b01, 2'b00, 2'b00, 12'h020, 12'h000, 0, 0, 2'b01, 32'h55);
        idle(2, 12'h020);
        drain();

        // reset lands while this read is in flight; it must never return
        beat(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 0, 0, 2'b01, 0);
        void'(sb.pop_back());
        do_reset();
        idle(int'(RD_LAT) + 3, 12'h000);

        check("final_pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
